// File: rtl/multicycle_sequencer_if.sv
// Instruction-memory fetch port between the sequencer (master) and instruction memory (slave).
// The address width tracks the sequencer's program counter width.
interface multicycle_sequencer_if #(
    parameter int PC_W = 8
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_valid;
    logic [15:0]     imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_valid,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_valid,
        output imem_data
    );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXEC -> WB per instruction,
// sticky HALT/TRAP on halt or illegal encodings. Every output comes from a register.
module multicycle_sequencer #(
    parameter int PC_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    multicycle_sequencer_if.master imem,
    output logic [3:0]             ALUop,
    output logic                   alu_en,
    output logic                   regWrite,
    output logic [2:0]             rd,
    output logic [2:0]             rs,
    output logic [PC_W-1:0]        pc,
    output logic                   busy,
    output logic                   halted,
    output logic                   illegal
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_AR    = 5'b00010;
    localparam logic [4:0] OP_HALT  = 5'b11111;

    state_t          state_reg, state_next;
    logic [14:0]     ir_reg;
    logic [3:0]      aluop_reg;
    logic [2:0]      rd_reg, rs_reg;
    logic [PC_W-1:0] pc_reg;

    // Instruction register keeps everything but the unused bit 4:
    // [14:10] opcode, [9:7] rd, [6:4] rs, [3:0] funct.
    logic [4:0] opcode;
    logic [3:0] funct;
    logic       r_legal;
    assign opcode  = ir_reg[14:10];
    assign funct   = ir_reg[3:0];
    assign r_legal = (opcode == OP_RTYPE) && (funct <= 4'd8);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (start) state_next = S_FETCH;
            S_FETCH:  if (imem.imem_valid) state_next = S_DECODE;
            S_DECODE: begin
                if (r_legal || opcode == OP_AR) begin
                    state_next = S_EXEC;
                end else if (opcode == OP_HALT) begin
                    state_next = S_HALT;
                end else begin
                    state_next = S_TRAP;
                end
            end
            S_EXEC:   state_next = S_WB;
            S_WB:     state_next = S_FETCH;
            S_HALT:   state_next = S_HALT;
            S_TRAP:   state_next = S_TRAP;
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        imem.imem_req = 1'b0;
        alu_en        = 1'b0;
        regWrite      = 1'b0;
        busy          = 1'b0;
        halted        = 1'b0;
        illegal       = 1'b0;
        case (state_reg)
            S_FETCH:  begin imem.imem_req = 1'b1; busy = 1'b1; end
            S_DECODE: busy = 1'b1;
            S_EXEC:   begin alu_en = 1'b1; busy = 1'b1; end
            S_WB:     begin regWrite = 1'b1; busy = 1'b1; end
            S_HALT:   halted = 1'b1;
            S_TRAP:   illegal = 1'b1;
            default:  ;
        endcase
    end

    // ALUop/rd/rs persist across instructions; halt and illegal words leave ALUop as it was.
    always_ff @(posedge clk) begin
        if (reset) begin
            ir_reg    <= '0;
            aluop_reg <= '0;
            rd_reg    <= '0;
            rs_reg    <= '0;
            pc_reg    <= '0;
        end else begin
            if (state_reg == S_FETCH && imem.imem_valid) begin
                ir_reg <= {imem.imem_data[15:5], imem.imem_data[3:0]};
            end
            if (state_reg == S_DECODE) begin
                rd_reg <= ir_reg[9:7];
                rs_reg <= ir_reg[6:4];
                if (r_legal) begin
                    aluop_reg <= funct;
                end else if (opcode == OP_AR) begin
                    aluop_reg <= 4'b1111;
                end
            end
            if (state_reg == S_WB) begin
                pc_reg <= pc_reg + PC_W'(1);
            end
        end
    end

    assign imem.imem_addr = pc_reg;
    assign pc             = pc_reg;
    assign ALUop          = aluop_reg;
    assign rd             = rd_reg;
    assign rs             = rs_reg;
endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench: a per-cycle expected-output schedule is derived from the program
// in memory and the chosen fetch wait counts, then compared against two DUT widths.
module tb_multicycle_sequencer;
    localparam int MAXC = 400;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        imem_valid;
    logic [15:0] imem_data;

    always #5 clk = ~clk;

    multicycle_sequencer_if #(.PC_W(8)) bus1 ();
    multicycle_sequencer_if #(.PC_W(2)) bus2 ();
    assign bus1.imem_valid = imem_valid;
    assign bus1.imem_data  = imem_data;
    assign bus2.imem_valid = imem_valid;
    assign bus2.imem_data  = imem_data;

    logic [3:0] op1, op2;
    logic       alu1, alu2, wr1, wr2, busy1, busy2, halt1, halt2, ill1, ill2;
    logic [2:0] rd1, rs1, rd2, rs2;
    logic [7:0] pc1;
    logic [1:0] pc2;

    multicycle_sequencer #(.PC_W(8)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .imem(bus1),
        .ALUop(op1), .alu_en(alu1), .regWrite(wr1), .rd(rd1), .rs(rs1),
        .pc(pc1), .busy(busy1), .halted(halt1), .illegal(ill1)
    );

    multicycle_sequencer #(.PC_W(2)) u_dut2 (
        .clk(clk), .reset(reset), .start(start), .imem(bus2),
        .ALUop(op2), .alu_en(alu2), .regWrite(wr2), .rd(rd2), .rs(rs2),
        .pc(pc2), .busy(busy2), .halted(halt2), .illegal(ill2)
    );

    // Packed view: {req, addr[7:0], alu_en, regWrite, busy, halted, illegal, pc[7:0], ALUop, rd, rs}
    logic [31:0] obs1, obs2;
    assign obs1 = {bus1.imem_req, bus1.imem_addr, alu1, wr1, busy1, halt1, ill1, pc1, op1, rd1, rs1};
    assign obs2 = {bus2.imem_req, 6'd0, bus2.imem_addr, alu2, wr2, busy2, halt2, ill2,
                   6'd0, pc2, op2, rd2, rs2};

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] mem   [0:255];
    int          waits [0:255];
    logic [31:0] e_vec  [0:MAXC-1];
    logic [31:0] e_mask [0:MAXC-1];
    bit          e_valid[0:MAXC-1];
    int          e_nwr;

    task automatic set_cyc(input int c, input bit req, input int addr, input bit vld,
                           input bit alu, input bit wr, input bit bsy, input bit hlt,
                           input bit ill, input int pcv, input int op, input int rdv, input int rsv);
        if (c >= MAXC) return;
        e_vec[c]   = {req, 8'(addr), alu, wr, bsy, hlt, ill, 8'(pcv), 4'(op < 0 ? 0 : op), 3'(rdv), 3'(rsv)};
        e_mask[c]  = (op < 0) ? 32'hFFFF_FC3F : 32'hFFFF_FFFF;
        e_valid[c] = vld;
    endtask

    // Walks the program instruction by instruction: fetch takes waits+1 cycles, then
    // decode, exec, write-back; halt/illegal words park the sequencer for good.
    task automatic build_model(input int pcw, input int ncyc);
        int c, pcv, fi, op_m, rd_m, rs_m, st, opc, fn;
        logic [15:0] w;
        c = 0; pcv = 0; fi = 0; op_m = 0; rd_m = 0; rs_m = 0; st = 0; e_nwr = 0;
        while (c < ncyc) begin
            if (st != 0) begin
                set_cyc(c, 0, pcv, 0, 0, 0, 0, st == 1, st == 2, pcv, op_m, rd_m, rs_m);
                c++;
                continue;
            end
            for (int k = 0; k <= waits[fi] && c < ncyc; k++) begin
                set_cyc(c, 1, pcv, k == waits[fi], 0, 0, 1, 0, 0, pcv, op_m, rd_m, rs_m);
                c++;
            end
            fi++;
            w = mem[pcv];
            set_cyc(c, 0, pcv, 0, 0, 0, 1, 0, 0, pcv, op_m, rd_m, rs_m);
            c++;
            opc  = int'(w[15:11]);
            fn   = int'(w[3:0]);
            rd_m = int'(w[10:8]);
            rs_m = int'(w[7:5]);
            if (opc == 31) begin
                st = 1; op_m = -1;
            end else if ((opc == 0 && fn <= 8) || opc == 2) begin
                op_m = (opc == 2) ? 15 : fn;
                set_cyc(c, 0, pcv, 0, 1, 0, 1, 0, 0, pcv, op_m, rd_m, rs_m);
                c++;
                set_cyc(c, 0, pcv, 0, 0, 1, 1, 0, 0, pcv, op_m, rd_m, rs_m);
                if (c < ncyc) e_nwr++;
                c++;
                pcv = (pcv + 1) % (1 << pcw);
            end else begin
                st = 2; op_m = -1;
            end
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1; start = 1'b0; imem_valid = 1'b0; imem_data = 16'h0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_prog(input int pcw, input int ncyc, input bit rand_start, input string name,
                            output int nwr, output int nreq_first);
        logic [31:0] obs;
        bit          seen_alu;
        int          addr;
        nwr = 0; nreq_first = 0; seen_alu = 0;
        build_model(pcw, ncyc);
        apply_reset();
        start = 1'b1;
        @(negedge clk);
        for (int c = 0; c < ncyc; c++) begin
            obs = (pcw == 2) ? obs2 : obs1;
            start = rand_start ? 1'($urandom_range(0, 1)) : 1'b0;
            n_checks++;
            if ((obs & e_mask[c]) !== (e_vec[c] & e_mask[c])) begin
                n_fail++;
                $display("FAIL %s cycle %0d {req,addr,alu,wr,busy,halt,ill,pc,op,rd,rs}: got %h want %h (mask %h)",
                         name, c, obs, e_vec[c], e_mask[c]);
                break;
            end
            if (obs[21]) nwr++;
            if (obs[22]) seen_alu = 1;
            if (!seen_alu && obs[31]) nreq_first++;
            addr       = int'(obs[30:23]);
            imem_valid = e_valid[c];
            imem_data  = e_valid[c] ? mem[addr] : 16'($urandom);
            @(negedge clk);
        end
        imem_valid = 1'b0;
        start      = 1'b0;
        $display("run %s: %0d cycles, %0d regWrite pulses", name, ncyc, nwr);
    endtask

    function automatic logic [15:0] rand_legal();
        logic [15:0] w;
        w = 16'($urandom);
        if ($urandom_range(0, 3) == 0) begin
            w[15:11] = 5'b00010;
        end else begin
            w[15:11] = 5'b00000;
            w[3:0]   = 4'($urandom_range(0, 8));
        end
        return w;
    endfunction

    function automatic logic [15:0] rand_illegal();
        logic [15:0] w;
        logic [4:0]  opc;
        w = 16'($urandom);
        if ($urandom_range(0, 1) == 0) begin
            w[15:11] = 5'b00000;
            w[3:0]   = 4'($urandom_range(9, 15));
        end else begin
            opc = 5'($urandom_range(1, 30));
            if (opc == 5'b00010) opc = 5'b00111;
            w[15:11] = opc;
        end
        return w;
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) begin
            mem[i]   = 16'hF800;
            waits[i] = 0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; imem_valid = 1'b1; imem_data = 16'h0000;
        repeat (2) @(negedge clk);
        n_checks++;
        if (obs1 !== 32'h0) begin n_fail++; $display("FAIL reset_outputs_w8: got %h want %h", obs1, 32'h0); end
        n_checks++;
        if (obs2 !== 32'h0) begin n_fail++; $display("FAIL reset_outputs_w2: got %h want %h", obs2, 32'h0); end
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (obs1 !== 32'h0) begin n_fail++; $display("FAIL idle_hold: got %h want %h", obs1, 32'h0); end
        imem_valid = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_basic();
        int nwr, nreq;
        clear_prog();
        mem[0] = 16'h0000;
        mem[1] = {5'b00010, 3'($urandom), 3'($urandom), 1'b0, 4'($urandom)};
        mem[2] = {5'b00000, 3'($urandom), 3'($urandom), 1'b0, 4'b1000};
        mem[3] = 16'hF800;
        run_prog(8, 24, 1'b0, "basic", nwr, nreq);
        n_checks++;
        if (nwr !== 3) begin n_fail++; $display("FAIL basic_regwrite_count: got %0d want 3", nwr); end
        n_checks++;
        if (nreq !== 1) begin n_fail++; $display("FAIL basic_fetch_cycles: got %0d want 1", nreq); end
    endtask

    task automatic test_wait();
        int nwr, nreq;
        clear_prog();
        mem[0]   = rand_legal();
        waits[0] = 5;
        run_prog(8, 20, 1'b1, "wait", nwr, nreq);
        n_checks++;
        if (nreq !== 6) begin n_fail++; $display("FAIL wait_req_cycles: got %0d want 6", nreq); end
        n_checks++;
        if (nwr !== 1) begin n_fail++; $display("FAIL wait_regwrite_count: got %0d want 1", nwr); end
    endtask

    task automatic test_illegal();
        int nwr, nreq;
        clear_prog();
        mem[0] = 16'h0000;
        mem[1] = {5'b00000, 3'($urandom), 3'($urandom), 1'b0, 4'($urandom_range(9, 15))};
        run_prog(8, 30, 1'b1, "illegal_funct", nwr, nreq);
        n_checks++;
        if (nwr !== 1) begin n_fail++; $display("FAIL illegal_funct_regwrite: got %0d want 1", nwr); end
        clear_prog();
        mem[0] = 16'h3800;
        run_prog(8, 20, 1'b1, "illegal_opcode", nwr, nreq);
        n_checks++;
        if (nwr !== 0) begin n_fail++; $display("FAIL illegal_opcode_regwrite: got %0d want 0", nwr); end
    endtask

    task automatic test_random();
        int nwr, nreq, r;
        for (int it = 0; it < 3; it++) begin
            for (int i = 0; i < 256; i++) begin
                r = int'($urandom_range(0, 99));
                if (r < 3)      mem[i] = {5'b11111, 11'($urandom)};
                else if (r < 6) mem[i] = rand_illegal();
                else            mem[i] = rand_legal();
                waits[i] = int'($urandom_range(0, 3));
            end
            run_prog(8, 300, 1'b1, "random", nwr, nreq);
            n_checks++;
            if (nwr !== e_nwr) begin n_fail++; $display("FAIL random_regwrite_count: got %0d want %0d", nwr, e_nwr); end
        end
    endtask

    task automatic test_wrap();
        int nwr, nreq;
        clear_prog();
        for (int i = 0; i < 4; i++) begin
            mem[i] = {5'b00000, 3'($urandom), 3'($urandom), 1'($urandom), 4'($urandom_range(0, 8))};
        end
        for (int i = 0; i < 256; i++) waits[i] = int'($urandom_range(0, 2));
        run_prog(2, 80, 1'b1, "wrap_pcw2", nwr, nreq);
        n_checks++;
        if (nwr < 5) begin n_fail++; $display("FAIL wrap_instr_count: got %0d want at least 5", nwr); end
    endtask

    task automatic test_reset_mid();
        bit found;
        found = 0;
        apply_reset();
        imem_valid = 1'b1;
        imem_data  = 16'h0763;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (alu1 === 1'b1) begin found = 1; break; end
            @(negedge clk);
        end
        n_checks++;
        if (found !== 1'b1) begin n_fail++; $display("FAIL reset_mid_reach_exec: got %0d want 1", found); end
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (obs1 !== 32'h0) begin n_fail++; $display("FAIL reset_mid_outputs: got %h want %h", obs1, 32'h0); end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (obs1 !== 32'h0) begin n_fail++; $display("FAIL reset_mid_no_wb: got %h want %h", obs1, 32'h0); end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (obs1 !== 32'h8010_0000) begin
            n_fail++; $display("FAIL reset_mid_refetch: got %h want %h", obs1, 32'h8010_0000);
        end
        imem_valid = 1'b0;
        $display("test_reset_mid done");
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; imem_valid = 1'b0; imem_data = 16'h0;
        test_reset();
        test_basic();
        test_wait();
        test_illegal();
        test_random();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
